// File: rtl/otter_crypto_unit.sv
// otter_crypto_unit: multi-cycle Feistel execution unit for the OTTER ENCRY
// instruction (func3 010 = encrypt, 011 = decrypt). A 32-bit block is split
// into 16-bit halves, and the unit runs one round per clock behind a
// START/BUSY/DONE handshake.
// Optional build macro CRYPTO_UNROLL2_EN: evaluate two rounds per RUN cycle.
// Its results are bit-identical to the single-round build.
module otter_crypto_unit #(
   parameter int unsigned ROUNDS = 8,
   parameter int unsigned KEY_W  = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             CRYPTO_SEL,
   input  logic [31:0]      DATA_IN,
   input  logic [KEY_W-1:0] KEY_IN,
   output logic             BUSY,
   output logic             DONE,
   output logic [31:0]      RESULT
);

   localparam int unsigned HALF_W = 16;
   localparam int unsigned BLK_W  = 2 * HALF_W;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [HALF_W-1:0] l_q, l_d;
   logic [HALF_W-1:0] r_q, r_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic              mode_q, mode_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [BLK_W-1:0]  result_q, result_d;

   // Round datapath results for the current RUN cycle
   logic [BLK_W-1:0]  step1_c;
   logic [BLK_W-1:0]  lr_c;
   logic              last_c;
   logic [CNT_W-1:0]  cnt_adv_c;

   // Round key: even indices use the low key half, odd indices the high half
   function automatic logic [HALF_W-1:0] round_key(input logic [KEY_W-1:0] key,
                                                   input logic [CNT_W-1:0] idx);
      logic [HALF_W-1:0] base;
      base = idx[0] ? key[31:16] : key[15:0];
      return base ^ HALF_W'(idx);
   endfunction

   // F(x,k): rotate-left-by-3 XOR 16-bit wrapping sum
   function automatic logic [HALF_W-1:0] feistel_f(input logic [HALF_W-1:0] x,
                                                   input logic [HALF_W-1:0] k);
      logic [HALF_W-1:0] sum;
      sum = x + k;
      return {x[12:0], x[15:13]} ^ sum;
   endfunction

   // One Feistel round on {L,R}; decrypt undoes the encrypt round of the same index
   function automatic logic [BLK_W-1:0] do_round(input logic             dec,
                                                 input logic [BLK_W-1:0] lr,
                                                 input logic [KEY_W-1:0] key,
                                                 input logic [CNT_W-1:0] idx);
      logic [HALF_W-1:0] l;
      logic [HALF_W-1:0] r;
      logic [HALF_W-1:0] k;
      l = lr[BLK_W-1:HALF_W];
      r = lr[HALF_W-1:0];
      k = round_key(key, idx);
      if (dec) begin
         return {r ^ feistel_f(l, k), l};
      end
      return {r, l ^ feistel_f(r, k)};
   endfunction

`ifdef CRYPTO_UNROLL2_EN
   logic [BLK_W-1:0] step2_c;
   logic [CNT_W-1:0] cnt_nx_c;
   logic             has_second_c;

   // Two rounds per cycle; the second is skipped when only one index remains
   always_comb begin
      step1_c      = do_round(mode_q, {l_q, r_q}, key_q, cnt_q);
      cnt_nx_c     = mode_q ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
      has_second_c = mode_q ? (cnt_q != '0) : (cnt_q != LAST_IDX);
      step2_c      = do_round(mode_q, step1_c, key_q, cnt_nx_c);
      lr_c         = has_second_c ? step2_c : step1_c;
      last_c       = mode_q ? (cnt_q <= CNT_W'(1))
                            : ((5'(cnt_q) + 5'd1) >= 5'(LAST_IDX));
      cnt_adv_c    = mode_q ? (cnt_q - CNT_W'(2)) : (cnt_q + CNT_W'(2));
   end
`else
   // One round per cycle; encrypt ascends to ROUNDS-1, decrypt descends to 0
   always_comb begin
      step1_c   = do_round(mode_q, {l_q, r_q}, key_q, cnt_q);
      lr_c      = step1_c;
      last_c    = mode_q ? (cnt_q == '0) : (cnt_q == LAST_IDX);
      cnt_adv_c = mode_q ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
   end
`endif

   // State and datapath registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         l_q      <= '0;
         r_q      <= '0;
         key_q    <= '0;
         mode_q   <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         l_q      <= l_d;
         r_q      <= r_d;
         key_q    <= key_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // Next-state logic; START is only honoured in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START)  state_d = S_RUN;
         S_RUN:   if (last_c) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values; BUSY/DONE follow the next state
   always_comb begin
      l_d      = l_q;
      r_d      = r_q;
      key_d    = key_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      busy_d   = (state_d == S_RUN);
      done_d   = (state_d == S_FIN);
      case (state_q)
         S_IDLE: begin
            if (START) begin
               l_d    = DATA_IN[31:16];
               r_d    = DATA_IN[15:0];
               key_d  = KEY_IN;
               mode_d = CRYPTO_SEL;
               cnt_d  = CRYPTO_SEL ? LAST_IDX : '0;
            end
         end
         S_RUN: begin
            l_d = lr_c[BLK_W-1:HALF_W];
            r_d = lr_c[HALF_W-1:0];
            if (last_c) begin
               result_d = lr_c;
            end else begin
               cnt_d = cnt_adv_c;
            end
         end
         default: ;
      endcase
   end

   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_otter_crypto_unit.sv
// Bench for otter_crypto_unit: three instances (ROUNDS = 1, 8, 7) share the
// stimulus, and each one is checked against a loop-based cipher model.
module tb_otter_crypto_unit;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        sel   = 1'b0;
   logic [31:0] data  = '0;
   logic [31:0] key   = '0;

   logic [2:0]  busy_w;
   logic [2:0]  done_w;
   logic [31:0] res_w [3];

   int          pass_cnt  = 0;
   int          total_cnt = 0;

   int          lat_obs [3];
   int          n_done  [3];
   int          n_busy  [3];
   logic [31:0] res_obs [3];

   always #5 clk = ~clk;

   otter_crypto_unit #(.ROUNDS(1), .KEY_W(32)) u_r1 (
      .CLK(clk), .RST_N(rst_n), .START(start), .CRYPTO_SEL(sel),
      .DATA_IN(data), .KEY_IN(key),
      .BUSY(busy_w[0]), .DONE(done_w[0]), .RESULT(res_w[0]));

   otter_crypto_unit #(.ROUNDS(8), .KEY_W(32)) u_r8 (
      .CLK(clk), .RST_N(rst_n), .START(start), .CRYPTO_SEL(sel),
      .DATA_IN(data), .KEY_IN(key),
      .BUSY(busy_w[1]), .DONE(done_w[1]), .RESULT(res_w[1]));

   otter_crypto_unit #(.ROUNDS(7), .KEY_W(32)) u_r7 (
      .CLK(clk), .RST_N(rst_n), .START(start), .CRYPTO_SEL(sel),
      .DATA_IN(data), .KEY_IN(key),
      .BUSY(busy_w[2]), .DONE(done_w[2]), .RESULT(res_w[2]));

   function automatic int rounds_of(input int j);
      case (j)
         0:       return 1;
         1:       return 8;
         default: return 7;
      endcase
   endfunction

   function automatic int exp_lat(input int r);
`ifdef CRYPTO_UNROLL2_EN
      return (r + 1) / 2 + 1;
`else
      return r + 1;
`endif
   endfunction

   // Reference cipher computed directly from the round definitions
   function automatic logic [15:0] mdl_f(input logic [15:0] x, input logic [15:0] k);
      logic [15:0] s;
      s = x + k;
      return {x[12:0], x[15:13]} ^ s;
   endfunction

   function automatic logic [31:0] model(input logic d_sel, input logic [31:0] d,
                                         input logic [31:0] k, input int rounds);
      logic [15:0] l, r, ki, t;
      logic [3:0]  idx;
      l = d[31:16];
      r = d[15:0];
      for (int n = 0; n < rounds; n++) begin
         idx = d_sel ? 4'(rounds - 1 - n) : 4'(n);
         ki  = (idx[0] ? k[31:16] : k[15:0]) ^ {12'b0, idx};
         if (!d_sel) begin
            t = l ^ mdl_f(r, ki);
            l = r;
            r = t;
         end else begin
            t = r ^ mdl_f(l, ki);
            r = l;
            l = t;
         end
      end
      return {l, r};
   endfunction

   // Issue one operation, observe every instance for a fixed window, check masked ones
   task automatic run_op(input logic o_sel, input logic [31:0] o_data,
                         input logic [31:0] o_key, input logic [2:0] mask,
                         input bit disturb, input string name);
      logic [31:0] exp_res;
      int          el;
      @(posedge clk); #1;
      start = 1'b1; sel = o_sel; data = o_data; key = o_key;
      @(posedge clk); #1;
      start = 1'b0; sel = 1'($urandom); data = $urandom; key = $urandom;
      for (int j = 0; j < 3; j++) begin
         lat_obs[j] = -1; n_done[j] = 0; n_busy[j] = 0; res_obs[j] = '0;
      end
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         for (int j = 0; j < 3; j++) begin
            if (done_w[j] === 1'b1) begin
               n_done[j]++;
               if (lat_obs[j] < 0) begin
                  lat_obs[j] = c;
                  res_obs[j] = res_w[j];
               end
            end
            if (busy_w[j] === 1'b1) n_busy[j]++;
         end
         if (disturb) begin
            if (c == 3 || c == 5) begin
               start = 1'b1; sel = ~o_sel; data = $urandom; key = $urandom;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (mask[j]) begin
            exp_res = model(o_sel, o_data, o_key, rounds_of(j));
            el      = exp_lat(rounds_of(j));
            total_cnt++;
            if (res_obs[j] !== exp_res)
               $display("FAIL %s result r%0d: got %h exp %h", name, rounds_of(j), res_obs[j], exp_res);
            else pass_cnt++;
            total_cnt++;
            if (lat_obs[j] !== el)
               $display("FAIL %s latency r%0d: got %0d exp %0d", name, rounds_of(j), lat_obs[j], el);
            else pass_cnt++;
            total_cnt++;
            if (n_done[j] !== 1)
               $display("FAIL %s done_count r%0d: got %0d exp 1", name, rounds_of(j), n_done[j]);
            else pass_cnt++;
            total_cnt++;
            if (n_busy[j] !== el - 1)
               $display("FAIL %s busy_cycles r%0d: got %0d exp %0d", name, rounds_of(j), n_busy[j], el - 1);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         start = 1'b1; sel = 1'($urandom); data = $urandom; key = $urandom;
         @(negedge clk);
         for (int j = 0; j < 3; j++) begin
            total_cnt++;
            if (busy_w[j] !== 1'b0) $display("FAIL reset_busy r%0d: got %b exp 0", rounds_of(j), busy_w[j]);
            else pass_cnt++;
            total_cnt++;
            if (done_w[j] !== 1'b0) $display("FAIL reset_done r%0d: got %b exp 0", rounds_of(j), done_w[j]);
            else pass_cnt++;
            total_cnt++;
            if (res_w[j] !== 32'h0) $display("FAIL reset_result r%0d: got %h exp 0", rounds_of(j), res_w[j]);
            else pass_cnt++;
         end
      end
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         total_cnt++;
         if (busy_w[j] !== 1'b0 || done_w[j] !== 1'b0)
            $display("FAIL post_reset_idle r%0d: got busy=%b done=%b exp 0/0", rounds_of(j), busy_w[j], done_w[j]);
         else pass_cnt++;
      end
   endtask

   task automatic test_single_round();
      run_op(1'b0, 32'h0000_0001, 32'h0, 3'b111, 1'b0, "single_enc");
      total_cnt++;
      if (res_obs[0] !== 32'h0001_0009)
         $display("FAIL single_enc_vector: got %h exp 00010009", res_obs[0]);
      else pass_cnt++;
      total_cnt++;
      if (lat_obs[0] !== 2) $display("FAIL single_enc_latency: got %0d exp 2", lat_obs[0]);
      else pass_cnt++;
      run_op(1'b1, 32'h0001_0009, 32'h0, 3'b111, 1'b0, "single_dec");
      total_cnt++;
      if (res_obs[0] !== 32'h0000_0001)
         $display("FAIL single_dec_vector: got %h exp 00000001", res_obs[0]);
      else pass_cnt++;
   endtask

   task automatic test_round_trip();
      logic [31:0] ct;
      run_op(1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 3'b111, 1'b0, "rt_enc");
      ct = model(1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 8);
      run_op(1'b1, ct, 32'hDEAD_BEEF, 3'b111, 1'b0, "rt_dec8");
      total_cnt++;
      if (res_obs[1] !== 32'h1234_5678) $display("FAIL round_trip_r8: got %h exp 12345678", res_obs[1]);
      else pass_cnt++;
      ct = model(1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 7);
      run_op(1'b1, ct, 32'hDEAD_BEEF, 3'b111, 1'b0, "rt_dec7");
      total_cnt++;
      if (res_obs[2] !== 32'h1234_5678) $display("FAIL round_trip_r7: got %h exp 12345678", res_obs[2]);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [31:0] d, k, ct;
      for (int n = 0; n < 10; n++) begin
         d = $urandom; k = $urandom;
         run_op(1'($urandom), d, k, 3'b111, 1'b0, "random");
      end
      d = $urandom; k = $urandom;
      ct = model(1'b0, d, k, 8);
      run_op(1'b1, ct, k, 3'b111, 1'b0, "random_rt");
      total_cnt++;
      if (res_obs[1] !== d) $display("FAIL random_round_trip_r8: got %h exp %h", res_obs[1], d);
      else pass_cnt++;
   endtask

   task automatic test_busy_isolation();
      // ROUNDS=1 instance is idle again by the re-pulses, so it is not checked here
      run_op(1'b0, 32'hCAFE_F00D, 32'h0BAD_1DEA, 3'b110, 1'b1, "isolation_enc");
      run_op(1'b1, 32'h5A5A_0FF0, 32'h1357_9BDF, 3'b110, 1'b1, "isolation_dec");
   endtask

   task automatic test_mid_reset();
      int dones;
      @(posedge clk); #1;
      start = 1'b1; sel = 1'b0; data = 32'h1234_5678; key = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      total_cnt++;
      if (busy_w[1] !== 1'b1) $display("FAIL mid_reset_precheck_busy r8: got %b exp 1", busy_w[1]);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
         total_cnt++;
         if (busy_w[j] !== 1'b0 || done_w[j] !== 1'b0 || res_w[j] !== 32'h0)
            $display("FAIL mid_reset_clear r%0d: got busy=%b done=%b res=%h exp 0/0/0",
                     rounds_of(j), busy_w[j], done_w[j], res_w[j]);
         else pass_cnt++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         for (int j = 0; j < 3; j++) if (done_w[j] !== 1'b0) dones++;
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL mid_reset_no_done: got %0d exp 0", dones);
      else pass_cnt++;
      run_op(1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 3'b111, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_single_round();
      test_round_trip();
      test_random();
      test_busy_isolation();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/otter_crypto_unit.md
Name: otter_crypto_unit

Overview:
- Multi-cycle execution unit for the OTTER ENCRY instruction (opcode 7'b0011100; func3 010 = encrypt, 011 = decrypt).
- Consumes the decoder's cryptoSel plus rs1 (data) and rs2 (key), and runs a 32-bit Feistel cipher one round per clock.
- Drives RESULT into register-file write mux input 4.
- Exposes a START/BUSY/DONE handshake so the pipeline or FSM stalls until the result is valid.

Parameters:
- ROUNDS, 8, number of Feistel rounds. Legal range 1..16.
- KEY_W, 32, key width. Fixed at 32; it exists only for port sizing.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  one-cycle request pulse; sampled only in IDLE.
- CRYPTO_SEL  input  1  0 = encrypt, 1 = decrypt; latched with START.
- DATA_IN  input  32  rs1 plaintext or ciphertext; latched with START.
- KEY_IN  input  KEY_W  rs2 key; latched with START.
- BUSY  output  1  high from the cycle after START is accepted until DONE is asserted, inclusive of neither.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  32  output block; held until the next accepted START.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, BUSY=0, DONE=0, RESULT=0, round counter=0, internal L/R/key/mode registers=0.
- Reset asserted mid-operation aborts the operation immediately; no DONE is produced.
- State machine:
  - IDLE: START=1 -> latch L=DATA_IN[31:16], R=DATA_IN[15:0], key, mode; counter = 0 (encrypt) or ROUNDS-1 (decrypt); go to RUN.
  - RUN: BUSY=1; one round per cycle. After the round using index 0 (decrypt) or ROUNDS-1 (encrypt), go to FIN.
  - FIN: DONE=1, BUSY=0, RESULT={L,R} registered; return to IDLE next cycle.
- Latency: START accepted in cycle t -> DONE in cycle t+ROUNDS+1. Throughput is one operation per ROUNDS+2 cycles.
- Round key for index i: k_i = (i even ? key[15:0] : key[31:16]) ^ {12'b0, i[3:0]}.
- Round function: F(x,k) = {x[12:0],x[15:13]} ^ ((x+k) mod 2^16). All arithmetic is 16-bit and wraps; no carry-out.
- Encrypt round i (i = 0..ROUNDS-1, ascending): L'=R, R'=L^F(R,k_i).
- Decrypt round i (i = ROUNDS-1..0, descending): R'=L, L'=R^F(L,k_i).
- Decrypt is the exact inverse of encrypt for the same key and ROUNDS.
- START while BUSY or in FIN is ignored; no queueing and no error flag.
- Latched inputs are immune to DATA_IN, KEY_IN and CRYPTO_SEL changes after acceptance.
- ROUNDS=1: RUN lasts exactly one cycle.
- Counter is 4 bits and never wraps in normal operation; the encrypt end compare is against ROUNDS-1.

Optional Feature:
- Macro: CRYPTO_UNROLL2_EN.
- Defined:
  - RUN evaluates two consecutive rounds per cycle, in the same index order as the single-round form.
  - Latency becomes ceil(ROUNDS/2)+1.
  - For odd ROUNDS, the last cycle performs a single round.
  - Results are bit-identical to the single-round build.
- Undefined: one round per cycle as specified above.

Test Plan:
- Reset check: RST_N low with START=1 and random inputs -> BUSY=0, DONE=0, RESULT=0x00000000; no state change until RST_N rises.
- Single-round vector: ROUNDS=1, encrypt, KEY_IN=0x00000000, DATA_IN=0x00000001 -> DONE exactly 2 cycles after START, RESULT=0x00010009.
  - Then decrypt of 0x00010009 with the same key -> RESULT=0x00000001.
- Round trip: ROUNDS=8, KEY_IN=0xDEADBEEF, DATA_IN=0x12345678; encrypt then decrypt the result -> final RESULT=0x12345678.
  - DONE exactly 9 cycles after each START.
  - BUSY high for 8 cycles per operation.
- Busy and input isolation: START re-pulsed at cycles 3 and 5 of RUN with CRYPTO_SEL and DATA_IN changed -> ignored; only one DONE, and RESULT matches the original request.
- Mid-operation reset: assert RST_N=0 at cycle 4 of RUN -> outputs clear asynchronously (same cycle) and no DONE appears.
  - A new START after release completes normally with the correct value.
- CRYPTO_UNROLL2_EN build, ROUNDS=7, round-trip vector above -> same RESULT as the non-unrolled build; DONE 5 cycles after START.
